// File: rtl/geofence_host.sv
// Geofence host: buffers 7-point frames (target + hexagon) in two ping-pong slots,
// streams them to the geofence core and queues the core's verdicts in a 2-deep FIFO.
module geofence_host #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic [W-1:0] X,
  output logic [W-1:0] Y,
  input  logic         valid,
  input  logic         is_inside,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_inside,
  output logic [7:0]   frames_done
);

  localparam logic [0:0] ST_SEND = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Slot s occupies entries s*7 .. s*7+6; entry 0 of a slot is the target.
  logic [W-1:0] r_ptX [0:13];
  logic [W-1:0] r_ptY [0:13];

  logic [1:0]   r_full;
  logic         r_wrSlot;
  logic [2:0]   r_wrIdx;
  logic         r_rdSlot;

  logic [0:0]   r_state;
  logic [2:0]   r_sendIdx;
  logic         r_curReal;

  logic [1:0]   r_resCnt;
  logic [1:0]   r_resData;
  logic [7:0]   r_framesDone;

  logic         w_accept;
  logic         w_wrLast;
  logic [3:0]   w_wrAddr;
  logic [3:0]   w_rdAddr;
  logic         w_fire;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_resCntNext;
  logic         w_chooseReal;
  logic         w_freeSlot;
  logic         w_sending;
  logic [1:0]   w_fullNext;

  assign in_ready  = ~r_full[r_wrSlot];
  assign w_accept  = in_valid & in_ready;
  assign w_wrLast  = w_accept && (r_wrIdx == 3'd6);
  assign w_wrAddr  = (r_wrSlot ? 4'd7 : 4'd0) + {1'b0, r_wrIdx};
  assign w_rdAddr  = (r_rdSlot ? 4'd7 : 4'd0) + {1'b0, r_sendIdx};

  assign w_fire       = (r_state == ST_WAIT) && valid;
  assign w_push       = w_fire & r_curReal;
  assign w_pop        = (r_resCnt != 2'd0) & res_ready;
  assign w_resCntNext = r_resCnt + {1'b0, w_push} - {1'b0, w_pop};

  // A real frame is only launched when its result is guaranteed a FIFO entry,
  // which is what keeps the 2-deep result FIFO from ever overflowing.
  assign w_chooseReal = r_full[r_rdSlot] && (w_resCntNext <= 2'd1);
  assign w_freeSlot   = (r_state == ST_SEND) && (r_sendIdx == 3'd6) && r_curReal;

  assign w_sending = (r_state == ST_SEND) && r_curReal;
  assign X = w_sending ? r_ptX[w_rdAddr] : '0;
  assign Y = w_sending ? r_ptY[w_rdAddr] : '0;

  assign res_valid   = (r_resCnt != 2'd0);
  assign res_inside  = res_valid & r_resData[0];
  assign frames_done = r_framesDone;

  // Point storage needs no reset: a slot is only read once its full flag is set.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ptX[w_wrAddr] <= in_x;
      r_ptY[w_wrAddr] <= in_y;
    end
  end

  always_comb begin
    w_fullNext = r_full;
    if (w_wrLast) begin
      w_fullNext[r_wrSlot] = 1'b1;
    end
    if (w_freeSlot) begin
      w_fullNext[r_rdSlot] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full   <= 2'b00;
      r_wrSlot <= 1'b0;
      r_wrIdx  <= 3'd0;
      r_rdSlot <= 1'b0;
    end else begin
      r_full <= w_fullNext;
      if (w_accept) begin
        if (r_wrIdx == 3'd6) begin
          r_wrIdx  <= 3'd0;
          r_wrSlot <= ~r_wrSlot;
        end else begin
          r_wrIdx <= r_wrIdx + 3'd1;
        end
      end
      if (w_freeSlot) begin
        r_rdSlot <= ~r_rdSlot;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_SEND;
      r_sendIdx <= 3'd0;
      r_curReal <= 1'b0;
    end else begin
      case (r_state)
        ST_SEND: begin
          if (r_sendIdx == 3'd6) begin
            r_state   <= ST_WAIT;
            r_sendIdx <= 3'd0;
          end else begin
            r_sendIdx <= r_sendIdx + 3'd1;
          end
        end
        default: begin
          if (valid) begin
            r_state   <= ST_SEND;
            r_sendIdx <= 3'd0;
            r_curReal <= w_chooseReal;
          end
        end
      endcase
    end
  end

  // Head of the result FIFO is always entry 0; a pop shifts entry 1 down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resCnt     <= 2'd0;
      r_resData    <= 2'b00;
      r_framesDone <= 8'd0;
    end else begin
      r_resCnt <= w_resCntNext;
      case ({w_push, w_pop})
        2'b10: r_resData[r_resCnt[0]] <= is_inside;
        2'b01: r_resData[0] <= r_resData[1];
        2'b11: begin
          if (r_resCnt == 2'd1) begin
            r_resData[0] <= is_inside;
          end else begin
            r_resData[0] <= r_resData[1];
            r_resData[1] <= is_inside;
          end
        end
        default: ;
      endcase
      if (w_push) begin
        r_framesDone <= r_framesDone + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_geofence_host.sv
// Bench for geofence_host: a behavioural geofence core drives valid/is_inside, and a
// queue-based frame/result model predicts every output cycle by cycle.
module tb_geofence_host;

  localparam int W = 10;
  typedef logic [W-1:0] coordT;
  typedef struct packed {
    logic [6:0][W-1:0] x;
    logic [6:0][W-1:0] y;
  } frameT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  coordT       in_x = '0;
  coordT       in_y = '0;
  coordT       X;
  coordT       Y;
  logic        valid = 1'b0;
  logic        is_inside = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_inside;
  logic [7:0]  frames_done;

  always #5 clk = ~clk;

  geofence_host #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .X           (X),
    .Y           (Y),
    .valid       (valid),
    .is_inside   (is_inside),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_inside  (res_inside),
    .frames_done (frames_done)
  );

  int cmpCount = 0;
  int errCount = 0;

  // Model: frames completed upstream and not yet freed, the frame on the wire,
  // and the verdicts waiting to be consumed.
  int         mPhase;
  bit         mReal;
  frameT      mCur;
  frameT      frameQ[$];
  frameT      mPart;
  int         mPartCnt;
  bit         resQ[$];
  logic [7:0] mDone;
  bit         mAccepted;
  int         totalPushes;

  frameT srcQ[$];
  int    srcBeat;
  int    inRate;
  int    readyRate;
  int    delayMax;
  bit    strayEn;
  int    acceptedBeats;
  bit    popLog[$];

  int coreIdx;
  int coreDelay;
  int coreX[7];
  int coreY[7];
  bit coreFire;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic frameT makeFrame(input int tx, input int ty, input int ox, input int oy);
    int hx[6] = '{50, 100, 100, 50, 20, 20};
    int hy[6] = '{20, 40, 80, 100, 80, 40};
    frameT f;
    f.x[0] = coordT'(tx + ox);
    f.y[0] = coordT'(ty + oy);
    for (int k = 0; k < 6; k++) begin
      f.x[k+1] = coordT'(hx[k] + ox);
      f.y[k+1] = coordT'(hy[k] + oy);
    end
    return f;
  endfunction

  // Point-in-convex-polygon: the target lies strictly on the same side of every edge.
  function automatic bit coreInside();
    int pos = 0;
    int neg = 0;
    for (int i = 0; i < 6; i++) begin
      int j = (i + 1) % 6;
      int c = (coreX[1+j] - coreX[1+i]) * (coreY[0] - coreY[1+i])
            - (coreY[1+j] - coreY[1+i]) * (coreX[0] - coreX[1+i]);
      if (c > 0) pos++;
      if (c < 0) neg++;
    end
    return (pos == 6) || (neg == 6);
  endfunction

  task automatic modelReset();
    mPhase = 0;
    mReal = 1'b0;
    mCur = '0;
    frameQ.delete();
    mPart = '0;
    mPartCnt = 0;
    resQ.delete();
    mDone = 8'd0;
    mAccepted = 1'b0;
    coreIdx = 0;
    coreDelay = 0;
    coreFire = 1'b0;
  endtask

  task automatic modelUpdate();
    int preFrames = frameQ.size();
    int occ;
    bit pop = (resQ.size() > 0) && res_ready;
    bit fire = (mPhase == 7) && valid;
    bit push = fire && mReal;
    mAccepted = in_valid && (preFrames < 2);
    if (fire) begin
      occ = resQ.size() + int'(push) - int'(pop);
      mReal = (preFrames >= 1) && (occ <= 1);
      if (mReal) mCur = frameQ[0];
      mPhase = 0;
    end else if (mPhase < 7) begin
      if (mPhase == 6 && mReal) void'(frameQ.pop_front());
      mPhase++;
    end
    if (mAccepted) begin
      mPart.x[mPartCnt] = in_x;
      mPart.y[mPartCnt] = in_y;
      mPartCnt++;
      if (mPartCnt == 7) begin
        frameQ.push_back(mPart);
        mPartCnt = 0;
      end
    end
    if (pop) void'(resQ.pop_front());
    if (push) begin
      resQ.push_back(is_inside);
      mDone = mDone + 8'd1;
      totalPushes++;
    end
  endtask

  task automatic compareAll();
    coordT ex = '0;
    coordT ey = '0;
    if (mPhase < 7 && mReal) begin
      ex = mCur.x[mPhase];
      ey = mCur.y[mPhase];
    end
    checkOutput("X", 32'(X), 32'(ex));
    checkOutput("Y", 32'(Y), 32'(ey));
    checkOutput("inReady", 32'(in_ready), 32'(frameQ.size() < 2));
    checkOutput("resValid", 32'(res_valid), 32'(resQ.size() > 0));
    checkOutput("resInside", 32'(res_inside), (resQ.size() > 0) ? 32'(resQ[0]) : 32'd0);
    checkOutput("framesDone", 32'(frames_done), 32'(mDone));
  endtask

  // One clock cycle: core, producer and consumer drive, then the model steps and is compared.
  task automatic applyStimulus();
    coreFire = 1'b0;
    if (coreIdx < 7) begin
      coreX[coreIdx] = int'(X);
      coreY[coreIdx] = int'(Y);
      coreIdx++;
      if (coreIdx == 7) coreDelay = $urandom_range(0, delayMax);
      valid = strayEn && ($urandom_range(0, 7) == 0);
      is_inside = 1'($urandom_range(0, 1));
    end else if (coreDelay == 0) begin
      valid = 1'b1;
      is_inside = coreInside();
      coreFire = 1'b1;
    end else begin
      coreDelay--;
      valid = 1'b0;
      is_inside = 1'($urandom_range(0, 1));
    end
    if (srcQ.size() > 0 && $urandom_range(0, 99) < inRate) begin
      in_valid = 1'b1;
      in_x = srcQ[0].x[srcBeat];
      in_y = srcQ[0].y[srcBeat];
    end else begin
      in_valid = 1'b0;
      in_x = coordT'($urandom);
      in_y = coordT'($urandom);
    end
    res_ready = ($urandom_range(0, 99) < readyRate);
    if (res_valid && res_ready) popLog.push_back(res_inside);
    @(posedge clk);
    modelUpdate();
    if (mAccepted) begin
      acceptedBeats++;
      srcBeat++;
      if (srcBeat == 7) begin
        srcBeat = 0;
        void'(srcQ.pop_front());
      end
    end
    if (coreFire) coreIdx = 0;
    #1;
    compareAll();
  endtask

  task automatic resetDut();
    reset = 1'b0;
    in_valid = 1'b0;
    valid = 1'b0;
    is_inside = 1'b0;
    res_ready = 1'b0;
    srcQ.delete();
    srcBeat = 0;
    popLog.delete();
    acceptedBeats = 0;
    totalPushes = 0;
    modelReset();
    #1;
    compareAll();
    repeat (2) begin
      @(posedge clk);
      #1;
      compareAll();
    end
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time %0t reached limit 2000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit hit;
    inRate = 0;
    readyRate = 100;
    delayMax = 2;
    strayEn = 1'b0;

    $display("[TB] idle after reset");
    resetDut();
    for (int i = 0; i < 7; i++) begin
      checkOutput("idleX", 32'(X), 0);
      checkOutput("idleY", 32'(Y), 0);
      applyStimulus();
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("idleResValid", 32'(res_valid), 0);
      checkOutput("idleDone", 32'(frames_done), 0);
    end

    $display("[TB] hexagon frames inside and outside");
    resetDut();
    inRate = 100;
    readyRate = 100;
    delayMax = 3;
    srcQ.push_back(makeFrame(60, 60, 0, 0));
    hit = 1'b0;
    for (int n = 0; n < 80 && !hit; n++) begin
      applyStimulus();
      hit = (mDone == 8'd1);
    end
    checkOutput("hexReached", 32'(hit), 1);
    checkOutput("hexResValid", 32'(res_valid), 1);
    checkOutput("hexInside", 32'(res_inside), 1);
    checkOutput("hexDone", 32'(frames_done), 1);
    srcQ.push_back(makeFrame(200, 10, 0, 0));
    hit = 1'b0;
    for (int n = 0; n < 80 && !hit; n++) begin
      applyStimulus();
      hit = (mDone == 8'd2);
    end
    checkOutput("outReached", 32'(hit), 1);
    checkOutput("outResValid", 32'(res_valid), 1);
    checkOutput("outInside", 32'(res_inside), 0);
    checkOutput("outDone", 32'(frames_done), 2);

    $display("[TB] three frames with consumer stalled");
    resetDut();
    inRate = 100;
    readyRate = 0;
    delayMax = 1;
    srcQ.push_back(makeFrame(60, 60, 0, 0));
    srcQ.push_back(makeFrame(200, 10, 0, 0));
    srcQ.push_back(makeFrame(70, 50, 0, 0));
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      applyStimulus();
      hit = (acceptedBeats == 14);
    end
    checkOutput("slotsFilled", 32'(hit), 1);
    checkOutput("slotFullReady", 32'(in_ready), 0);
    repeat (100) applyStimulus();
    checkOutput("heldDone", 32'(frames_done), 2);
    checkOutput("heldResValid", 32'(res_valid), 1);
    checkOutput("heldInReady", 32'(in_ready), 1);
    readyRate = 100;
    hit = 1'b0;
    for (int n = 0; n < 150 && !hit; n++) begin
      applyStimulus();
      hit = (popLog.size() >= 3);
    end
    checkOutput("drainReached", 32'(hit), 1);
    if (popLog.size() >= 3) begin
      checkOutput("order1", 32'(popLog[0]), 1);
      checkOutput("order2", 32'(popLog[1]), 0);
      checkOutput("order3", 32'(popLog[2]), 1);
    end
    checkOutput("drainDone", 32'(frames_done), 3);

    $display("[TB] reset in the middle of a frame");
    resetDut();
    inRate = 100;
    readyRate = 0;
    delayMax = 2;
    srcQ.push_back(makeFrame(60, 60, 0, 0));
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      applyStimulus();
      hit = (resQ.size() == 1) && (mPhase == 3);
    end
    checkOutput("midReached", 32'(hit), 1);
    checkOutput("midPreResValid", 32'(res_valid), 1);
    reset = 1'b0;
    #1;
    checkOutput("rstX", 32'(X), 0);
    checkOutput("rstY", 32'(Y), 0);
    checkOutput("rstInReady", 32'(in_ready), 1);
    checkOutput("rstResValid", 32'(res_valid), 0);
    checkOutput("rstResInside", 32'(res_inside), 0);
    checkOutput("rstDone", 32'(frames_done), 0);
    resetDut();
    readyRate = 100;
    repeat (20) applyStimulus();

    $display("[TB] randomized traffic");
    inRate = 60;
    readyRate = 70;
    delayMax = 3;
    strayEn = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      resetDut();
      for (int n = 0; n < 1200; n++) begin
        if (srcQ.size() < 2) begin
          srcQ.push_back(makeFrame($urandom_range(0, 130), $urandom_range(0, 130),
                                   $urandom_range(0, 800), $urandom_range(0, 800)));
        end
        applyStimulus();
      end
    end

    $display("[TB] frame counter wrap");
    resetDut();
    inRate = 100;
    readyRate = 100;
    delayMax = 0;
    strayEn = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 6000 && !hit; n++) begin
      if (srcQ.size() < 2) begin
        srcQ.push_back(makeFrame($urandom_range(0, 130), $urandom_range(0, 130),
                                 $urandom_range(0, 800), $urandom_range(0, 800)));
      end
      applyStimulus();
      hit = (totalPushes >= 260);
    end
    checkOutput("wrapReached", 32'(hit), 1);
    if (hit) checkOutput("wrapDone", 32'(frames_done), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
